// File: rtl/cs12_mib_pkg.sv
// Shared definitions for the CS12 MIB slave core: register map, slave FSM
// states, STATUS field layout and the north-stream LFSR step.
package cs12_mib_pkg;

    localparam logic [19:0] OFS_ID      = 20'h00000;
    localparam logic [19:0] OFS_SCRATCH = 20'h00004;
    localparam logic [19:0] OFS_STATUS  = 20'h00008;
    localparam logic [19:0] OFS_CTRL    = 20'h0000C;

    localparam int unsigned CNT_W           = 16;
    localparam int unsigned STATUS_ERR_LSB  = 16;
    localparam int unsigned STATUS_WORD_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR2,
        ST_WR_HI,
        ST_WR_LO,
        ST_WR_ACK,
        ST_RD_TURN,
        ST_RD_HI,
        ST_RD_LO
    } mib_state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

endpackage

// File: rtl/cs12_mib_lfsr_checker.sv
// North-stream checker: even parity over data+parity bit and LFSR sequence
// continuity, with a wrapping word counter and a saturating error counter.
module cs12_lfsr_checker
    import cs12_mib_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             valid,
    input  logic [7:0]       data,
    input  logic             parity,
    input  logic             clear,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             led
);

    logic       seeded;
    logic [7:0] prev;
    logic       bad;

    // A word is bad on parity alone, or on sequence once a seed exists
    always_comb begin
        bad = (^{parity, data}) | (seeded & (data != lfsr_next(prev)));
    end

    // Seed/prev tracking and counters; a clear in the same clock as a valid
    // word wins, and that word becomes the new uncounted seed
    always_ff @(posedge clk) begin
        if (srst) begin
            seeded   <= 1'b0;
            prev     <= '0;
            word_cnt <= '0;
            err_cnt  <= '0;
        end else if (clear) begin
            word_cnt <= '0;
            err_cnt  <= '0;
            seeded   <= valid;
            if (valid)
                prev <= data;
        end else if (valid) begin
            word_cnt <= word_cnt + 1'b1;
            if (bad && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
            prev   <= data;
            seeded <= 1'b1;
        end
    end

    // Health indicator follows the counters by one clock
    always_ff @(posedge clk) begin
        if (srst)
            led <= 1'b0;
        else
            led <= (word_cnt != '0) && (err_cnt == '0);
    end

endmodule

// File: rtl/cs12_mib_top.sv
// CS12 core: MIB bus slave with ID/SCRATCH/STATUS/CTRL registers, plus the
// north high-speed stream checker and its registered forward to the south.
module cs12_mib_top
    import cs12_mib_pkg::*;
#(
    parameter logic [3:0]  P_MIB_MSN              = 4'h6,
    parameter int unsigned P_CMD_ACK_TIMEOUT_CLKS = 16,
    parameter logic [31:0] P_ID                   = 32'hC512_0001
)(
    input  logic         i_sysclk,
    input  logic         i_srst,
    input  logic         MIB_START,
    input  logic         MIB_RD_WR_N,
    inout  wire  [15:0]  MIB_AD,
    output logic         MIB_ACK,
    input  logic [47:36] HS_NORTH_IN,
    output logic [47:36] HS_SOUTH_OUT,
    output logic         led_check
);

    localparam logic [15:0] WD_LAST = 16'(P_CMD_ACK_TIMEOUT_CLKS - 1);

    logic         mst_start, mst_rd_wr_n;
    logic [15:0]  mst_ad;
    logic [47:36] mst_hs;

    mib_state_t   state;
    logic [7:0]   addr_hi;
    logic [15:0]  addr_lo, wdata_hi, wdata_lo, ad_out, wd_cnt;
    logic         is_rd, ad_oe;
    logic [31:0]  scratch, rdata, rd_mux;
    logic [19:0]  ofs;
    logic         sel, ctrl_clr;
    logic [CNT_W-1:0] word_cnt, err_cnt;

    assign MIB_AD = ad_oe ? ad_out : 'z;

    // Input capture and south forward
    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            mst_start    <= 1'b0;
            mst_rd_wr_n  <= 1'b0;
            mst_ad       <= '0;
            mst_hs       <= '0;
            HS_SOUTH_OUT <= '0;
        end else begin
            mst_start    <= MIB_START;
            mst_rd_wr_n  <= MIB_RD_WR_N;
            mst_ad       <= MIB_AD;
            mst_hs       <= HS_NORTH_IN;
            HS_SOUTH_OUT <= HS_NORTH_IN;
        end
    end

    always_comb begin
        ofs = {addr_hi[3:0], addr_lo};
        sel = (addr_hi[7:4] == P_MIB_MSN);
    end

    // Read data selection; STATUS is taken as one word so both halves agree
    always_comb begin
        rd_mux = '0;
        if (ofs[19:2] == OFS_ID[19:2])
            rd_mux = P_ID;
        else if (ofs[19:2] == OFS_SCRATCH[19:2])
            rd_mux = scratch;
        else if (ofs[19:2] == OFS_STATUS[19:2]) begin
            rd_mux[STATUS_ERR_LSB  +: CNT_W] = err_cnt;
            rd_mux[STATUS_WORD_LSB +: CNT_W] = word_cnt;
        end
    end

    // Counter clear lands on the same clock as the write ACK
    always_comb begin
        ctrl_clr = (state == ST_WR_ACK) && !mst_start && sel &&
                   (ofs[19:2] == OFS_CTRL[19:2]) && wdata_lo[0];
    end

    // Slave FSM with registered ACK/AD outputs; a new start always aborts and
    // restarts, and wd_cnt tracks transaction age so a stalled sequence falls
    // back to IDLE
    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state    <= ST_IDLE;
            MIB_ACK  <= 1'b0;
            ad_oe    <= 1'b0;
            ad_out   <= '0;
            scratch  <= '0;
            rdata    <= '0;
            addr_hi  <= '0;
            addr_lo  <= '0;
            wdata_hi <= '0;
            wdata_lo <= '0;
            is_rd    <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            MIB_ACK <= 1'b0;
            ad_oe   <= 1'b0;
            if (mst_start) begin
                addr_hi <= mst_ad[7:0];
                is_rd   <= mst_rd_wr_n;
                wd_cnt  <= '0;
                state   <= ST_ADDR2;
            end else if ((state != ST_IDLE) && (wd_cnt == WD_LAST)) begin
                wd_cnt <= '0;
                state  <= ST_IDLE;
            end else begin
                wd_cnt <= (state == ST_IDLE) ? '0 : wd_cnt + 1'b1;
                case (state)
                    ST_ADDR2: begin
                        addr_lo <= mst_ad;
                        state   <= is_rd ? ST_RD_TURN : ST_WR_HI;
                    end
                    ST_WR_HI: begin
                        wdata_hi <= mst_ad;
                        state    <= ST_WR_LO;
                    end
                    ST_WR_LO: begin
                        wdata_lo <= mst_ad;
                        state    <= ST_WR_ACK;
                    end
                    ST_WR_ACK: begin
                        if (sel) begin
                            MIB_ACK <= 1'b1;
                            if (ofs[19:2] == OFS_SCRATCH[19:2])
                                scratch <= {wdata_hi, wdata_lo};
                        end
                        state <= ST_IDLE;
                    end
                    ST_RD_TURN: begin
                        rdata <= rd_mux;
                        state <= ST_RD_HI;
                    end
                    ST_RD_HI: begin
                        if (sel) begin
                            MIB_ACK <= 1'b1;
                            ad_oe   <= 1'b1;
                            ad_out  <= rdata[31:16];
                        end
                        state <= ST_RD_LO;
                    end
                    ST_RD_LO: begin
                        if (sel) begin
                            MIB_ACK <= 1'b1;
                            ad_oe   <= 1'b1;
                            ad_out  <= rdata[15:0];
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    cs12_lfsr_checker u_checker (
        .clk      (i_sysclk),
        .srst     (i_srst),
        .valid    (mst_hs[38]),
        .data     (mst_hs[46:39]),
        .parity   (mst_hs[47]),
        .clear    (ctrl_clr),
        .word_cnt (word_cnt),
        .err_cnt  (err_cnt),
        .led      (led_check)
    );

endmodule

// File: tb/tb_cs12_mib_top.sv
// Directed + randomized bench for cs12_mib_top: MIB register access timing,
// slave selection, stream checker counters/LED and mid-transaction reset.
module tb_cs12_mib_top;

    logic         clk = 1'b0;
    logic         srst, start, rdwr, tb_oe;
    logic [15:0]  tb_ad;
    wire  [15:0]  mib_ad;
    logic         ack, led;
    logic [47:36] north, south;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    assign mib_ad = tb_oe ? tb_ad : 'z;

    cs12_mib_top #(
        .P_MIB_MSN              (4'h6),
        .P_CMD_ACK_TIMEOUT_CLKS (16),
        .P_ID                   (32'hC512_0001)
    ) dut (
        .i_sysclk     (clk),
        .i_srst       (srst),
        .MIB_START    (start),
        .MIB_RD_WR_N  (rdwr),
        .MIB_AD       (mib_ad),
        .MIB_ACK      (ack),
        .HS_NORTH_IN  (north),
        .HS_SOUTH_OUT (south),
        .led_check    (led)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Master write: start/addr1, addr2, data hi, data lo on consecutive clocks
    task automatic mib_write(input logic [23:0] addr, input logic [31:0] data, input logic exp_ack);
        tick(); start = 1'b1; rdwr = 1'b0; tb_oe = 1'b1; tb_ad = {8'h00, addr[23:16]};
        tick(); start = 1'b0; tb_ad = addr[15:0];
        tick(); tb_ad = data[31:16];
        tick(); tb_ad = data[15:0];
        tick(); tb_oe = 1'b0;
        chk("wr_ack_early", 32'(ack), 0);
        tick(); chk("wr_ack_t3", 32'(ack), 0);
        tick(); chk("wr_ack_t4", 32'(ack), 32'(exp_ack));
        tick(); chk("wr_ack_t5", 32'(ack), 0);
    endtask

    // Master read: start/addr1, addr2, then bus released for turnaround
    task automatic mib_read(input logic [23:0] addr, input logic exp_sel, output logic [31:0] data);
        logic [15:0] hi, lo;
        tick(); start = 1'b1; rdwr = 1'b1; tb_oe = 1'b1; tb_ad = {8'h00, addr[23:16]};
        tick(); start = 1'b0; tb_ad = addr[15:0];
        tick(); tb_oe = 1'b0;
        tick(); chk("rd_ack_t1", 32'(ack), 0);
        tick(); chk("rd_ack_t2", 32'(ack), 0);
        chk("rd_oe_t2", 32'(dut.ad_oe), 0);
        tick(); hi = mib_ad;
        chk("rd_ack_t3", 32'(ack), 32'(exp_sel));
        chk("rd_oe_t3", 32'(dut.ad_oe), 32'(exp_sel));
        tick(); lo = mib_ad;
        chk("rd_ack_t4", 32'(ack), 32'(exp_sel));
        chk("rd_oe_t4", 32'(dut.ad_oe), 32'(exp_sel));
        tick();
        chk("rd_ack_t5", 32'(ack), 0);
        chk("rd_oe_t5", 32'(dut.ad_oe), 0);
        data = {hi, lo};
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [11:0] mk_word(input logic v, input logic [7:0] d, input logic flip);
        return {(^d) ^ flip, d, v, 2'b00};
    endfunction

    // Expected STATUS after a fresh clear, from the checker rules
    function automatic logic [31:0] model_status(input logic [11:0] w[$]);
        int unsigned words = 0, errs = 0;
        logic        have_prev = 1'b0;
        logic [7:0]  prev = '0, d;
        logic        bad;
        foreach (w[i]) begin
            if (w[i][2]) begin
                d     = w[i][10:3];
                bad   = (^w[i][11:3]) != 1'b0;
                if (have_prev && d != ref_next(prev)) bad = 1'b1;
                words = (words + 1) % 65536;
                if (bad && errs < 65535) errs++;
                prev      = d;
                have_prev = 1'b1;
            end
        end
        return {errs[15:0], words[15:0]};
    endfunction

    // One word per clock; south must be the previous clock's north
    task automatic send_stream(input logic [11:0] w[$]);
        logic [11:0] last = '0;
        foreach (w[i]) begin
            tick();
            if (i > 0) chk("south_lag", 32'(south), 32'(last));
            north = w[i];
            last  = w[i];
        end
        tick(); chk("south_lag", 32'(south), 32'(last));
        north = '0;
        repeat (4) tick();
    endtask

    initial begin
        logic [31:0] rd, exp;
        logic [11:0] q[$];
        logic [7:0]  x;

        srst = 1'b1; start = 1'b0; rdwr = 1'b0; tb_oe = 1'b0; tb_ad = '0; north = '0;
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_oe", 32'(dut.ad_oe), 0);
        chk("rst_south", 32'(south), 0);
        chk("rst_led", 32'(led), 0);
        srst = 1'b0;
        tick();

        mib_write(24'h600004, 32'h0101_0202, 1'b1);
        mib_read(24'h600004, 1'b1, rd); chk("scratch_rd", rd, 32'h0101_0202);
        mib_read(24'h600000, 1'b1, rd); chk("id_rd", rd, 32'hC512_0001);
        mib_read(24'h600010, 1'b1, rd); chk("unmapped_rd", rd, 32'h0000_0000);
        mib_write(24'h600000, 32'hFFFF_FFFF, 1'b1);
        mib_read(24'h600000, 1'b1, rd); chk("id_ro", rd, 32'hC512_0001);
        mib_read(24'h600007, 1'b1, rd); chk("scratch_lowbits", rd, 32'h0101_0202);

        mib_read(24'h500004, 1'b0, rd);
        for (int i = 0; i < 10; i++) begin
            tick(); chk("unsel_timeout_ack", 32'(ack), 0);
        end
        mib_write(24'h500004, 32'hDEAD_BEEF, 1'b0);
        mib_read(24'h600004, 1'b1, rd); chk("unsel_no_write", rd, 32'h0101_0202);

        q = {}; x = 8'hAE;
        for (int i = 0; i < 100; i++) begin
            q.push_back(mk_word(1'b1, x, 1'b0));
            x = ref_next(x);
        end
        send_stream(q);
        mib_read(24'h600008, 1'b1, rd); chk("status_clean", rd, 32'h0000_0064);
        chk("led_clean", 32'(led), 1);

        mib_write(24'h60000C, 32'h0000_0001, 1'b1);
        q[50] = {~q[50][11], q[50][10:0]};
        send_stream(q);
        mib_read(24'h600008, 1'b1, rd); chk("status_par", rd, 32'h0001_0064);
        chk("led_par", 32'(led), 0);
        mib_write(24'h60000C, 32'h0000_0001, 1'b1);
        mib_read(24'h600008, 1'b1, rd); chk("status_clr", rd, 32'h0000_0000);
        chk("led_clr", 32'(led), 0);

        for (int r = 0; r < 4; r++) begin
            mib_write(24'h60000C, 32'h0000_0001, 1'b1);
            q = {}; x = 8'($urandom);
            for (int i = 0; i < 40; i++) begin
                logic v;
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) x = 8'($urandom);
                q.push_back(mk_word(v, x, (r != 0) && ($urandom_range(0, 9) == 0)));
                if (v) x = ref_next(x);
            end
            exp = model_status(q);
            send_stream(q);
            mib_read(24'h600008, 1'b1, rd); chk("status_rand", rd, exp);
            chk("led_rand", 32'(led), 32'((exp[15:0] != 0) && (exp[31:16] == 0)));
        end

        mib_write(24'h600004, 32'h1234_5678, 1'b1);
        tick(); start = 1'b1; rdwr = 1'b1; tb_oe = 1'b1; tb_ad = 16'h0060;
        tick(); start = 1'b0; tb_ad = 16'h0004;
        tick(); tb_oe = 1'b0;
        repeat (3) tick();
        chk("rst_mid_ack_hi", 32'(ack), 1);
        chk("rst_mid_ad_hi", 32'(mib_ad), 32'h1234);
        srst = 1'b1;
        tick();
        chk("rst_mid_ack", 32'(ack), 0);
        chk("rst_mid_oe", 32'(dut.ad_oe), 0);
        srst = 1'b0;
        tick();
        mib_read(24'h600004, 1'b1, rd); chk("rst_scratch", rd, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
